// File: rtl/cs_output_arbiter.sv
// Round-robin packet arbiter for one crossbar output port (N,S,W,E,L).
// Optional stall timeout is enabled with `define CS_ARB_TIMEOUT_EN.
module cs_output_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] req_i,
    input  logic [4:0] tail_i,
    input  logic       out_ready_i,
    output logic [4:0] grant_o,
    output logic [2:0] sel_o,
    output logic       xfer_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    localparam logic [2:0] SEL_NONE = 3'b111;

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [4:0] grant_q;
    logic [2:0] sel_q;
    logic       busy_q;
    logic       timeout_q;

    logic       pick_v;
    logic [2:0] pick;
    logic [3:0] idx;
    logic       tail_g;
    logic       xfer;
    logic [2:0] ptr_d;

    // Search starts at ptr and wraps modulo 5.
    always_comb begin
        pick_v = 1'b0;
        pick   = 3'd0;
        idx    = 4'd0;
        for (int i = 0; i < 5; i++) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!pick_v && req_i[idx[2:0]]) begin
                pick_v = 1'b1;
                pick   = idx[2:0];
            end
        end
    end

    assign xfer   = (|(grant_q & req_i)) & out_ready_i;
    assign tail_g = |(grant_q & tail_i);
    assign ptr_d  = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;

`ifdef CS_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       expire;

    assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_param;

    assign unused_timeout_param = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            grant_q   <= 5'd0;
            sel_q     <= SEL_NONE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef CS_ARB_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_v) begin
                        state_q <= LOCKED;
                        grant_q <= 5'(1) << pick;
                        sel_q   <= pick;
                        busy_q  <= 1'b1;
`ifdef CS_ARB_TIMEOUT_EN
                        cnt_q   <= 8'd0;
`endif
                    end
                end
                LOCKED: begin
                    if (xfer) begin
`ifdef CS_ARB_TIMEOUT_EN
                        cnt_q <= 8'd0;
`endif
                        if (tail_g) begin
                            state_q <= IDLE;
                            ptr_q   <= ptr_d;
                            grant_q <= 5'd0;
                            sel_q   <= SEL_NONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
`ifdef CS_ARB_TIMEOUT_EN
                        // Stall long enough: drop the lock so others progress.
                        if (expire) begin
                            state_q   <= IDLE;
                            ptr_q     <= ptr_d;
                            grant_q   <= 5'd0;
                            sel_q     <= SEL_NONE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                            cnt_q     <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign xfer_o    = xfer;
    assign timeout_o = timeout_q;

endmodule
